// File: rtl/pwm_reg_if.sv
// Byte-wide register port between the I2C byte layer and the PWM bank.
// Writes: a transfer happens on every clock edge where wr_en is high. There is
// no ready signal because the bank accepts one byte per cycle unconditionally.
// Reads: rd_addr is sampled on each clock edge, and rd_data returns the
// addressed shadow byte one cycle later.
interface pwm_reg_if;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rd_addr,
        output rd_data
    );
endinterface

// File: rtl/pwm_channel_bank.sv
// PCA9685-style PWM bank. One shared 12-bit counter drives every channel.
// ON/OFF values are double-buffered: the host writes the shadow copy, and the
// active copy reloads at each period wrap or when the bank leaves sleep.
module pwm_channel_bank #(
    parameter int         NUM_CHANNELS = 16,
    parameter logic [7:0] PRESCALE_RST = 8'h1E
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    pwm_reg_if.slave                bus,
    output logic [NUM_CHANNELS-1:0] pwm_o,
    output logic                    period_start_o
);

    // Mode and timebase state
    logic        sleep;
    logic [7:0]  prescale;
    logic [7:0]  presc_cnt;
    logic [11:0] counter;

    // Shadow (host-visible) and active (in-use) channel settings
    logic [11:0]             on_sh   [NUM_CHANNELS];
    logic [11:0]             off_sh  [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] on_full_sh;
    logic [NUM_CHANNELS-1:0] off_full_sh;
    logic [11:0]             on_act  [NUM_CHANNELS];
    logic [11:0]             off_act [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] on_full_act;
    logic [NUM_CHANNELS-1:0] off_full_act;

    // Decode results
    logic [7:0]              wr_off;
    logic [5:0]              wr_idx;
    logic [1:0]              wr_sub;
    logic                    ch_wr_hit;
    logic                    all_wr_hit;
    logic [NUM_CHANNELS-1:0] ch_we;
    logic                    mode_wr;
    logic                    presc_wr;
    logic                    sleep_next;
    logic                    wake;
    logic                    tick;
    logic                    wrap;
    logic                    load_active;
    logic [NUM_CHANNELS-1:0] pwm_next;
    logic [7:0]              rd_off;
    logic [5:0]              rd_idx;
    logic [7:0]              rd_next;

    // Write-address decode and the timebase control signals
    always_comb begin
        wr_off     = bus.wr_addr - 8'd6;
        wr_idx     = wr_off[7:2];
        ch_wr_hit  = bus.wr_en && (bus.wr_addr >= 8'h06) &&
                     ({2'b00, wr_off[7:2]} < 8'(NUM_CHANNELS));
        all_wr_hit = bus.wr_en && (bus.wr_addr >= 8'hFA) && (bus.wr_addr <= 8'hFD);
        // ALL_LED 0xFA..0xFD map onto sub-registers 0..3
        wr_sub     = all_wr_hit ? (bus.wr_addr[1:0] + 2'd2) : wr_off[1:0];
        ch_we      = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            ch_we[i] = all_wr_hit || (ch_wr_hit && (wr_idx == 6'(i)));
        end
        mode_wr     = bus.wr_en && (bus.wr_addr == 8'h00);
        presc_wr    = bus.wr_en && (bus.wr_addr == 8'hFE);
        sleep_next  = mode_wr ? bus.wr_data[4] : sleep;
        wake        = mode_wr && sleep && !bus.wr_data[4];
        tick        = !sleep && (presc_cnt == prescale);
        wrap        = tick && (counter == 12'hFFF);
        load_active = wrap || wake;
    end

    // MODE1 and PRE_SCALE registers; PRE_SCALE is only writable while asleep
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sleep    <= 1'b1;
            prescale <= PRESCALE_RST;
        end else begin
            sleep <= sleep_next;
            if (presc_wr && sleep) begin
                prescale <= (bus.wr_data < 8'd3) ? 8'd3 : bus.wr_data;
            end
        end
    end

    // Prescaler and counter, held at zero throughout sleep and on sleep entry/exit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_cnt <= '0;
            counter   <= '0;
        end else if (sleep || sleep_next) begin
            presc_cnt <= '0;
            counter   <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
            counter   <= counter + 12'd1;
        end else begin
            presc_cnt <= presc_cnt + 8'd1;
        end
    end

    // Shadow writes from the host and shadow-to-active reload
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                on_sh[i]   <= '0;
                off_sh[i]  <= '0;
                on_act[i]  <= '0;
                off_act[i] <= '0;
            end
            on_full_sh   <= '0;
            off_full_sh  <= '1;
            on_full_act  <= '0;
            off_full_act <= '1;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (ch_we[i]) begin
                    case (wr_sub)
                        2'd0: on_sh[i][7:0] <= bus.wr_data;
                        2'd1: begin
                            on_sh[i][11:8] <= bus.wr_data[3:0];
                            on_full_sh[i]  <= bus.wr_data[4];
                        end
                        2'd2: off_sh[i][7:0] <= bus.wr_data;
                        default: begin
                            off_sh[i][11:8] <= bus.wr_data[3:0];
                            off_full_sh[i]  <= bus.wr_data[4];
                        end
                    endcase
                end
                // The active copy takes the pre-write shadow, so a write in the
                // reload cycle only takes effect at the following reload
                if (load_active) begin
                    on_act[i]       <= on_sh[i];
                    off_act[i]      <= off_sh[i];
                    on_full_act[i]  <= on_full_sh[i];
                    off_full_act[i] <= off_full_sh[i];
                end
            end
        end
    end

    // Per-channel output level from the active settings; full-off wins over full-on
    always_comb begin
        pwm_next = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (off_full_act[i]) begin
                pwm_next[i] = 1'b0;
            end else if (on_full_act[i]) begin
                pwm_next[i] = 1'b1;
            end else if (on_act[i] < off_act[i]) begin
                pwm_next[i] = (counter >= on_act[i]) && (counter < off_act[i]);
            end else if (on_act[i] > off_act[i]) begin
                pwm_next[i] = (counter >= on_act[i]) || (counter < off_act[i]);
            end else begin
                pwm_next[i] = 1'b0;
            end
        end
    end

    // Registered outputs: PWM levels forced low in sleep, and the wrap pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pwm_o          <= '0;
            period_start_o <= 1'b0;
        end else begin
            pwm_o          <= sleep ? '0 : pwm_next;
            period_start_o <= wrap;
        end
    end

    // Read mux over the shadow registers; unmapped addresses and ALL_LED read 0
    always_comb begin
        rd_off  = bus.rd_addr - 8'd6;
        rd_idx  = rd_off[7:2];
        rd_next = '0;
        if (bus.rd_addr == 8'h00) begin
            rd_next = {3'b000, sleep, 4'b0000};
        end else if (bus.rd_addr == 8'hFE) begin
            rd_next = prescale;
        end else if (bus.rd_addr >= 8'h06) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (rd_idx == 6'(i)) begin
                    case (rd_off[1:0])
                        2'd0:    rd_next = on_sh[i][7:0];
                        2'd1:    rd_next = {3'b000, on_full_sh[i], on_sh[i][11:8]};
                        2'd2:    rd_next = off_sh[i][7:0];
                        default: rd_next = {3'b000, off_full_sh[i], off_sh[i][11:8]};
                    endcase
                end
            end
        end
    end

    // One-cycle registered read data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.rd_data <= '0;
        end else begin
            bus.rd_data <= rd_next;
        end
    end

endmodule

// File: tb/tb_pwm_channel_bank.sv
// Directed bench for pwm_channel_bank: register map, double buffering,
// duty cycles, sleep behaviour and asynchronous reset.
module tb_pwm_channel_bank;
    localparam int NCH = 16;

    // Clock and reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pwm_reg_if bus ();
    logic [NCH-1:0] pwm;
    logic           ps;

    pwm_channel_bank #(
        .NUM_CHANNELS (NCH),
        .PRESCALE_RST (8'h1E)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .bus            (bus),
        .pwm_o          (pwm),
        .period_start_o (ps)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Window statistics
    int         hi [NCH];
    int         ps_cnt;
    int         ps_at;
    int         fall0;
    int         busy_cnt;
    int         sch_k [4];
    logic [7:0] sch_a [4];
    logic [7:0] sch_d [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic check_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
        @(negedge clk);
        bus.rd_addr = a;
        @(negedge clk);
        check(tag, 32'(bus.rd_data), 32'(exp));
    endtask

    task automatic clear_sched();
        for (int j = 0; j < 4; j++) begin
            sch_k[j] = -1;
            sch_a[j] = 8'h00;
            sch_d[j] = 8'h00;
        end
    endtask

    // Samples n consecutive cycles at the falling edge; scheduled writes are
    // driven right after sample k so they land on the following rising edge.
    task automatic run_window(input int n);
        logic prev0;
        prev0    = pwm[0];
        ps_cnt   = 0;
        ps_at    = 0;
        fall0    = 0;
        busy_cnt = 0;
        for (int c = 0; c < NCH; c++) hi[c] = 0;
        for (int s = 1; s <= n; s++) begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) if (pwm[c]) hi[c]++;
            if (pwm != '0) busy_cnt++;
            if (ps) begin
                ps_cnt++;
                ps_at = s;
            end
            if (prev0 && !pwm[0] && fall0 == 0) fall0 = s;
            prev0 = pwm[0];
            bus.wr_en = 1'b0;
            for (int j = 0; j < 4; j++) begin
                if (sch_k[j] == s) begin
                    bus.wr_en   = 1'b1;
                    bus.wr_addr = sch_a[j];
                    bus.wr_data = sch_d[j];
                end
            end
        end
        bus.wr_en = 1'b0;
        clear_sched();
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = 8'h00;
        bus.wr_data = 8'h00;
        bus.rd_addr = 8'h00;
        rst_n       = 1'b0;
        clear_sched();
        repeat (3) @(negedge clk);
        check("rst_pwm", 32'(pwm), 32'h0);
        check("rst_rd_data", 32'(bus.rd_data), 32'h0);
        rst_n = 1'b1;

        // Idle after reset: asleep, so nothing toggles
        run_window(40);
        check("idle_pwm_busy", 32'(busy_cnt), 32'd0);
        check("idle_ps_cnt", 32'(ps_cnt), 32'd0);
        check_read("rst_mode1", 8'h00, 8'h10);
        check_read("rst_prescale", 8'hFE, 8'h1E);
        check_read("rst_ch0_off_h", 8'h09, 8'h10);
        check_read("rst_ch0_on_h", 8'h07, 8'h00);

        // PRE_SCALE while asleep, with clamping
        reg_write(8'hFE, 8'h01);
        check_read("presc_clamp", 8'hFE, 8'h03);
        reg_write(8'hFE, 8'h03);
        check_read("presc_3", 8'hFE, 8'h03);

        // Only SLEEP is stored in MODE1; unmapped and absent channels read 0
        reg_write(8'h00, 8'hFF);
        check_read("mode1_mask", 8'h00, 8'h10);
        reg_write(8'h02, 8'h55);
        check_read("unmapped_02", 8'h02, 8'h00);
        reg_write(8'h46, 8'h10);
        check_read("absent_ch16", 8'h46, 8'h00);

        // ALL_LED
        reg_write(8'hFD, 8'h00);
        check_read("all_clr_ch15", 8'h45, 8'h00);
        reg_write(8'hFD, 8'h10);
        check_read("all_set_ch0", 8'h09, 8'h10);
        check_read("all_set_ch15", 8'h45, 8'h10);
        check_read("all_led_rd", 8'hFD, 8'h00);

        // ch0 ON=0x000 OFF=0x800
        reg_write(8'h06, 8'h00); reg_write(8'h07, 8'h00);
        reg_write(8'h08, 8'h00); reg_write(8'h09, 8'h08);
        // ch1 ON=0xC00 OFF=0x400 (wrapping window)
        reg_write(8'h0A, 8'h00); reg_write(8'h0B, 8'h0C);
        reg_write(8'h0C, 8'h00); reg_write(8'h0D, 8'h04);
        // ch2 full-on and full-off together
        reg_write(8'h0F, 8'h10); reg_write(8'h11, 8'h10);
        // ch3 ON == OFF == 0x100
        reg_write(8'h12, 8'h00); reg_write(8'h13, 8'h01);
        reg_write(8'h14, 8'h00); reg_write(8'h15, 8'h01);
        // ch4 full-on
        reg_write(8'h17, 8'h10); reg_write(8'h19, 8'h00);
        check_read("ch1_on_h", 8'h0B, 8'h0C);

        // Wake: period 1, with mid-period writes and one write on the wrap edge
        reg_write(8'h00, 8'h00);
        sch_k[0] = 100;   sch_a[0] = 8'hFE; sch_d[0] = 8'h10;
        sch_k[1] = 4000;  sch_a[1] = 8'h09; sch_d[1] = 8'h01;
        sch_k[2] = 6000;  sch_a[2] = 8'h11; sch_d[2] = 8'h00;
        sch_k[3] = 16383; sch_a[3] = 8'h09; sch_d[3] = 8'h02;
        run_window(16384);
        check("p1_ch0_hi", 32'(hi[0]), 32'd8192);
        check("p1_ch0_fall", 32'(fall0), 32'd8193);
        check("p1_ch1_hi", 32'(hi[1]), 32'd8192);
        check("p1_ch2_hi", 32'(hi[2]), 32'd0);
        check("p1_ch3_hi", 32'(hi[3]), 32'd0);
        check("p1_ch4_hi", 32'(hi[4]), 32'd16384);
        check("p1_ch5_hi", 32'(hi[5]), 32'd0);
        check("p1_ps_cnt", 32'(ps_cnt), 32'd1);
        check("p1_ps_at", 32'(ps_at), 32'd16384);

        // Period 2: OFF=0x100 from the mid-period write, ch2 now full-on
        run_window(16384);
        check("p2_ch0_hi", 32'(hi[0]), 32'd1024);
        check("p2_ch0_fall", 32'(fall0), 32'd1025);
        check("p2_ch1_hi", 32'(hi[1]), 32'd8192);
        check("p2_ch2_hi", 32'(hi[2]), 32'd16384);
        check("p2_ps_at", 32'(ps_at), 32'd16384);

        // Period 3: OFF=0x200 from the write that landed on the wrap edge
        run_window(16384);
        check("p3_ch0_hi", 32'(hi[0]), 32'd2048);
        check("p3_ch0_fall", 32'(fall0), 32'd2049);
        check("p3_ps_cnt", 32'(ps_cnt), 32'd1);
        check_read("presc_ignored", 8'hFE, 8'h03);
        check_read("ch0_off_h_sh", 8'h09, 8'h02);
        check_read("ch2_off_h_sh", 8'h11, 8'h00);

        // Sleep entry mid-period
        reg_write(8'h00, 8'h10);
        run_window(2000);
        check("sleep_busy", 32'(busy_cnt), 32'd0);
        check("sleep_ch4_hi", 32'(hi[4]), 32'd0);
        check("sleep_ps_cnt", 32'(ps_cnt), 32'd0);
        check_read("sleep_mode1", 8'h00, 8'h10);

        // Wake again: counting restarts from 0
        reg_write(8'h00, 8'h00);
        run_window(2100);
        check("wake_ch0_fall", 32'(fall0), 32'd2049);
        check("wake_ch4_hi", 32'(hi[4]), 32'd2100);
        check("wake_ch1_hi", 32'(hi[1]), 32'd2100);
        check("wake_ps_cnt", 32'(ps_cnt), 32'd0);

        // Asynchronous reset while running
        @(negedge clk);
        check("pre_rst_ch4", 32'(pwm[4]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_pwm", 32'(pwm), 32'h0);
        check("async_rst_ps", 32'(ps), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        check_read("arst_mode1", 8'h00, 8'h10);
        check_read("arst_prescale", 8'hFE, 8'h1E);
        check_read("arst_ch0_off_h", 8'h09, 8'h10);
        check_read("arst_ch2_on_h", 8'h0F, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
